div_seq: RTL and testbench
==========================

DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width in bits.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset  input  1  reset, asynchronous, active-low.
REQ-004 enable  input  1  advance enable; when 0 in RUN, the datapath and iteration counter hold.
REQ-005 start  input  1  request; accepted only in IDLE or DONE.
REQ-006 dividend  input  WIDTH  unsigned numerator, sampled on the accepting edge.
REQ-007 divisor  input  WIDTH  unsigned denominator, sampled on the accepting edge.
REQ-008 busy  output  1  high while in RUN.
REQ-009 done  output  1  single-cycle pulse; results are valid.
REQ-010 quotient  output  WIDTH  floor(dividend/divisor).
REQ-011 remainder  output  WIDTH  dividend mod divisor.
REQ-012 div_by_zero  output  1  set with done when the sampled divisor is 0.

Function
REQ-013 The FSM SHALL have states IDLE, RUN and DONE; reset enters IDLE.
REQ-014 IDLE/DONE + start=1 -> RUN: the block captures the operands, clears the partial remainder, loads the counter with WIDTH and clears div_by_zero.
REQ-015 DONE + start=0 -> IDLE after exactly one cycle; done=1 only in DONE.
REQ-016 RUN: each edge with enable=1 performs one restoring iteration, MSB first: shift {rem, q} left by 1, then trial-subtract divisor; if there is no borrow, keep the difference and set the q LSB.
REQ-017 The trial subtraction SHALL be WIDTH+1 bits wide so the borrow is exact for divisor values up to 2^WIDTH-1.
REQ-018 RUN -> DONE on the enabled edge that completes iteration WIDTH; latency with enable held at 1 = WIDTH+1 edges from the accepting edge to done=1.
REQ-019 Each cycle with enable=0 in RUN extends the latency by exactly one cycle; enable has no effect in IDLE or DONE.
REQ-020 A start in RUN SHALL be ignored; the operands are not resampled.
REQ-021 Divisor 0: the block keeps the same fixed latency, then quotient=all ones, remainder=captured dividend, div_by_zero=1.
REQ-022 quotient, remainder and div_by_zero SHALL hold their values from done until the next accepting edge, and stay stable throughout RUN.
REQ-023 A start in DONE is accepted back-to-back; done falls and busy rises on the same edge.

Reset
REQ-024 reset=0 SHALL immediately force IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, counter=0, and clear the internal operand registers.
REQ-025 Reset during RUN SHALL abort the operation with no done pulse; the first start after reset release behaves as from power-up.

Structure
REQ-026 Package div_pkg SHALL hold the state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the default WIDTH constant.
REQ-027 Sub-module div_step SHALL be the combinational single iteration: inputs partial remainder, quotient, divisor; outputs next remainder and next quotient. div_seq instantiates it once.
REQ-028 Counter width SHALL be clog2(WIDTH+1); no multiplier or divider operators are permitted.

Verification
REQ-029 100/7, enable=1 -> done at edge 33 after start, quotient=14, remainder=2, div_by_zero=0.
REQ-030 0xFFFFFFFF/1 and 5/0xFFFFFFFF -> (0xFFFFFFFF, 0) and (0, 5).
REQ-031 1234/0 -> quotient=0xFFFFFFFF, remainder=1234, div_by_zero=1, done at edge 33.
REQ-032 Start 100/7, then enable=0 for 5 cycles mid-RUN, plus a second start at edge 10 with 9/3 -> done at edge 38, result 14 r 2.
REQ-033 Reset pulsed at edge 16 of RUN -> all outputs 0 at once, no done; then 81/9 -> 9 r 0.
REQ-034 Back-to-back: start held through DONE with 50/6 after 100/7 -> two done pulses 33 edges apart, results 14r2 then 8r2.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider.
//   state_e   : FSM state encoding (IDLE/RUN/DONE)
//   WIDTH_DEF : default operand/result width
package div_pkg;
  localparam int WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;
endpackage

// File: rtl/div_seq_if.sv
// Request/result bundle of the sequential divider.
//   master : drives enable, start, dividend, divisor; sees the results
//   slave  : the divider side
interface div_seq_if
  import div_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);
  logic             enable;
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output enable, start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  enable, start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/div_seq_step.sv
// One restoring-division iteration, purely combinational.
//   rem_i/quo_i : partial remainder and quotient/dividend shift register
//   dvs_i       : divisor
//   rem_o/quo_o : state after shifting {rem,quo} left and trial-subtracting
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] diff;
  logic           borrow;

  // The partial remainder is always below the divisor (or, for a zero
  // divisor, holds only the dividend bits shifted in so far), so the
  // shifted value is < 2*divisor and a WIDTH+1 bit difference is enough:
  // its top bit is set exactly when the subtraction borrows.
  assign rem_sh = {rem_i, quo_i[WIDTH-1]};
  assign diff   = rem_sh - {1'b0, dvs_i};
  assign borrow = diff[WIDTH];

  assign rem_o = borrow ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
  assign quo_o = {quo_i[WIDTH-2:0], ~borrow};
endmodule

// File: rtl/div_seq.sv
// Sequential unsigned restoring divider, one quotient bit per enabled cycle.
//   clk   : rising-edge clock
//   reset : asynchronous, active-low
//   bus   : div_seq_if.slave -- start/enable/operands in,
//           busy/done/quotient/remainder/div_by_zero out
// A start in IDLE or DONE captures the operands; WIDTH enabled cycles later
// the results are loaded into the output registers and done pulses.
// Outputs hold from done until the next accepted start.
module div_seq
  import div_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input logic        clk,
  input logic        reset,
  div_seq_if.slave   bus
);
  localparam int CW = $clog2(WIDTH + 1);

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
  logic [WIDTH-1:0] rem_d, quo_d;
  logic             busy_q, done_q, dbz_q;
  logic [WIDTH-1:0] quot_out_q, rem_out_q;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dvs_i (dvs_q),
    .rem_o (rem_d),
    .quo_o (quo_d)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvs_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dbz_q      <= 1'b0;
      quot_out_q <= '0;
      rem_out_q  <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
            rem_q   <= '0;
            quo_q   <= bus.dividend;
            dvs_q   <= bus.divisor;
            cnt_q   <= CW'(WIDTH);
            dbz_q   <= 1'b0;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          if (bus.enable) begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q - CW'(1);
            // Last iteration: publish the step outputs directly so done
            // and the results appear on the same edge.
            if (cnt_q == CW'(1)) begin
              state_q    <= DONE;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
              quot_out_q <= quo_d;
              rem_out_q  <= rem_d;
              dbz_q      <= (dvs_q == '0);
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.quotient    = quot_out_q;
  assign bus.remainder   = rem_out_q;
  assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_div_seq.sv
// Scoreboard bench for div_seq: expected results are queued when an
// operation is started and checked whenever done is seen.
module tb_div_seq;
  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
  } res_t;

  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_err = 0;
  res_t sb[$];

  always #5 clk = ~clk;

  div_seq_if #(.WIDTH(W)) bus ();

  div_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    res_t e;
    if (b == '0) begin
      e.q = '1; e.r = a; e.z = 1'b1;
    end else begin
      e.q = a / b; e.r = a % b; e.z = 1'b0;
    end
    return e;
  endfunction

  // Result monitor: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    res_t e;
    if (reset === 1'b1 && bus.done === 1'b1) begin
      if (sb.size() == 0) chk("spurious_done", 1, 0);
      else begin
        e = sb.pop_front();
        chk("quotient", bus.quotient, e.q);
        chk("remainder", bus.remainder, e.r);
        chk("div_by_zero", bus.div_by_zero, e.z);
      end
    end
  end

  // Drive start before the next edge; returns just after the accepting edge.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    sb.push_back(model(a, b));
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  // Latency counted with the accepting edge as edge 1.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        lat = i + 2;
        return;
      end
    end
    chk("done_timeout", 0, 1);
  endtask

  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b);
    int lat;
    start_op(a, b);
    chk("busy_run", bus.busy, 1);
    wait_done(lat);
    chk("latency", lat, 33);
    chk("busy_done", bus.busy, 0);
    @(posedge clk); #1;
    chk("done_pulse", bus.done, 0);
  endtask

  initial begin
    int lat;
    int lat2;
    reset        = 1'b0;
    bus.enable   = 1'b1;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_quot", bus.quotient, 0);
    chk("rst_rem", bus.remainder, 0);
    chk("rst_dbz", bus.div_by_zero, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;

    op(32'd100, 32'd7);
    op(32'hFFFF_FFFF, 32'd1);
    op(32'd5, 32'hFFFF_FFFF);
    op(32'd1234, 32'd0);
    op(32'hFFFF_FFFE, 32'hFFFF_FFFF);
    op(32'h8000_0000, 32'h8000_0001);
    for (int k = 0; k < 4; k++) op($urandom, $urandom_range(1, 1 << (8 * k + 4)));

    // Stall for 5 cycles and attempt an ignored restart at edge 10.
    start_op(32'd100, 32'd7);
    lat = -1;
    for (int e = 2; e <= 60; e++) begin
      bus.enable = !(e >= 5 && e <= 9);
      if (e == 10) begin
        bus.start = 1'b1; bus.dividend = 32'd9; bus.divisor = 32'd3;
      end else bus.start = 1'b0;
      @(posedge clk); #1;
      if (e == 10) chk("ignored_start_busy", bus.busy, 1);
      if (bus.done) begin
        lat = e;
        break;
      end
    end
    chk("stall_latency", lat, 38);
    bus.enable = 1'b1;
    bus.start  = 1'b0;
    @(posedge clk); #1;

    // Abort mid-run; outputs clear immediately and no done follows.
    start_op(32'd100, 32'd7);
    repeat (15) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    void'(sb.pop_back());
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    chk("abort_quot", bus.quotient, 0);
    chk("abort_rem", bus.remainder, 0);
    chk("abort_dbz", bus.div_by_zero, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_no_done", bus.done, 0);
    op(32'd81, 32'd9);

    // Back-to-back: start held through DONE.
    start_op(32'd100, 32'd7);
    bus.start    = 1'b1;
    bus.dividend = 32'd50;
    bus.divisor  = 32'd6;
    sb.push_back(model(32'd50, 32'd6));
    wait_done(lat);
    chk("b2b_lat1", lat, 33);
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("b2b_done_fall", bus.done, 0);
    chk("b2b_busy_rise", bus.busy, 1);
    wait_done(lat2);
    chk("b2b_lat2", lat2, 33);
    repeat (3) @(posedge clk);
    chk("sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
